// File: rtl/ts_usb_out_reader.sv
// ts_usb_out_reader
//   Drains the USB bulk-OUT endpoint buffer (EP2 OUT) one byte per cycle and
//   emits a TS byte stream (ts_usb_data + ts_usb_writereq) toward the TS filter
//   input path. Downstream backpressure comes from ts_usb_almost_full. Once a
//   buffer has been consumed the endpoint is re-armed with a one-cycle pulse.
//   With SYNC_CHECK=1, bytes are forwarded only while aligned to PKT_LEN-byte
//   packets starting with SYNC_BYTE; garbage before a sync byte is dropped.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   ep2_usb_out_has_data       endpoint buffer holds an unread packet
//   ep2_usb_out_len[10:0]      valid bytes in the buffer (0..1024)
//   ep2_usb_out_addr[10:0]     buffer read address (registered)
//   ep2_usb_out_data[7:0]      buffer read data, valid one cycle after addr
//   ep2_usb_out_arm            one-cycle pulse: buffer consumed, re-arm
//   ts_usb_data[7:0]           output TS byte
//   ts_usb_writereq            output byte strobe
//   ts_usb_almost_full         downstream has only its >=2 byte margin left
//   fifo_aclr                  synchronous clear of the alignment state
//   in_sync                    alignment locked
//   drop_cnt, sync_loss_cnt    dropped bytes / lock losses (16 bit, wrap)
//   buf_cnt                    consumed endpoint buffers (16 bit, wrap)
//   arm_timeout_cnt            re-arm handshake timeouts (8 bit, wrap)
//   state_dbg[2:0]             current FSM state encoding
//
// Handshake: a byte is read from the endpoint only in a READ cycle where
// ts_usb_almost_full is low; it appears on ts_usb_writereq exactly two cycles
// later. At most one byte is ever in flight, which the downstream margin
// absorbs, so there is no ready signal on the output side.
module ts_usb_out_reader #(
  parameter int unsigned PKT_LEN     = 188,
  parameter logic [7:0]  SYNC_BYTE   = 8'h47,
  parameter bit          SYNC_CHECK  = 1'b1,
  parameter int unsigned ARM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ep2_usb_out_has_data,
  input  logic [10:0] ep2_usb_out_len,
  output logic [10:0] ep2_usb_out_addr,
  input  logic [7:0]  ep2_usb_out_data,
  output logic        ep2_usb_out_arm,
  output logic [7:0]  ts_usb_data,
  output logic        ts_usb_writereq,
  input  logic        ts_usb_almost_full,
  input  logic        fifo_aclr,
  output logic        in_sync,
  output logic [15:0] drop_cnt,
  output logic [15:0] sync_loss_cnt,
  output logic [15:0] buf_cnt,
  output logic [7:0]  arm_timeout_cnt,
  output logic [2:0]  state_dbg
);

  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_DRAIN    = 3'd2,
    S_ARM      = 3'd3,
    S_ARM_WAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   addr_q, addr_d;
  logic          rd_v_q, rd_v_d;
  logic          arm_q, arm_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;
  logic [PW-1:0] pkt_pos_q, pkt_pos_d;
  logic          in_sync_q, in_sync_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   loss_q, loss_d;
  logic [15:0]   buf_q, buf_d;
  logic [7:0]    tmo_q, tmo_d;

  // Alignment view after a same-cycle fifo_aclr: an in-flight byte is judged
  // as if it sat at packet position 0 with the lock already released.
  logic [PW-1:0] pos_eff;
  logic          sync_eff;
  logic [PW-1:0] pos_next;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    rd_v_d  = 1'b0;
    timer_d = timer_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (ep2_usb_out_has_data) begin
          if (ep2_usb_out_len != 11'd0) begin
            len_d   = ep2_usb_out_len;
            addr_d  = 11'd0;
            state_d = S_READ;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_READ: begin
        if (!ts_usb_almost_full) begin
          rd_v_d = 1'b1;
          if (addr_q == len_q - 11'd1) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_ARM;
      end
      S_ARM: begin
        timer_d = '0;
        state_d = S_ARM_WAIT;
      end
      S_ARM_WAIT: begin
        if (!ep2_usb_out_has_data) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(ARM_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          tmo_d   = tmo_q + 8'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The arm pulse is registered so it is high exactly while in S_ARM.
    arm_d = (state_d == S_ARM);
    buf_d = arm_d ? (buf_q + 16'd1) : buf_q;
  end

  always_comb begin
    pos_eff   = fifo_aclr ? '0 : pkt_pos_q;
    sync_eff  = fifo_aclr ? 1'b0 : in_sync_q;
    pos_next  = (pos_eff == PW'(PKT_LEN - 1)) ? '0 : (pos_eff + PW'(1));
    pkt_pos_d = pos_eff;
    in_sync_d = sync_eff;
    drop_d    = drop_q;
    loss_d    = loss_q;
    wr_d      = 1'b0;
    data_d    = data_q;

    if (rd_v_q) begin
      if (!SYNC_CHECK) begin
        wr_d   = 1'b1;
        data_d = ep2_usb_out_data;
      end else if ((pos_eff != '0) || (ep2_usb_out_data == SYNC_BYTE)) begin
        wr_d      = 1'b1;
        data_d    = ep2_usb_out_data;
        pkt_pos_d = pos_next;
        in_sync_d = 1'b1;
      end else begin
        // Packet boundary without a sync byte: discard and release the lock.
        drop_d = drop_q + 16'd1;
        if (sync_eff) begin
          loss_d    = loss_q + 16'd1;
          in_sync_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      rd_v_q    <= 1'b0;
      arm_q     <= 1'b0;
      timer_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      pkt_pos_q <= '0;
      in_sync_q <= 1'b0;
      drop_q    <= '0;
      loss_q    <= '0;
      buf_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rd_v_q    <= rd_v_d;
      arm_q     <= arm_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      pkt_pos_q <= pkt_pos_d;
      in_sync_q <= in_sync_d;
      drop_q    <= drop_d;
      loss_q    <= loss_d;
      buf_q     <= buf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign ep2_usb_out_addr = addr_q;
  assign ep2_usb_out_arm  = arm_q;
  assign ts_usb_data      = data_q;
  assign ts_usb_writereq  = wr_q;
  assign in_sync          = in_sync_q;
  assign drop_cnt         = drop_q;
  assign sync_loss_cnt    = loss_q;
  assign buf_cnt          = buf_q;
  assign arm_timeout_cnt  = tmo_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/ts_usb_out_reader.md
Name: ts_usb_out_reader

Overview:
- Drains USB bulk-OUT endpoint buffer (EP2 OUT) byte-by-byte and emits a TS byte stream (data + write strobe) toward the TS filter input path, i.e. the insel=100 source.
- Applies backpressure from the downstream almost_full.
- Re-arms the endpoint after each buffer.
- Optionally enforces 188-byte TS alignment on sync byte 0x47, dropping garbage until resync.

Parameters:
PKT_LEN, 188, TS packet length in bytes
SYNC_BYTE, 8'h47, TS sync byte value
SYNC_CHECK, 1, 1 = enforce alignment/drop; 0 = pass all bytes
ARM_TIMEOUT, 15, cycles to wait for has_data deassert after arm

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ep2_usb_out_has_data  in  1  endpoint buffer holds an unread packet
ep2_usb_out_len  in  11  valid bytes in buffer (0..1024)
ep2_usb_out_addr  out  11  buffer read address
ep2_usb_out_data  in  8  buffer read data, valid 1 cycle after addr
ep2_usb_out_arm  out  1  one-cycle pulse: buffer consumed, re-arm endpoint
ts_usb_data  out  8  output TS byte
ts_usb_writereq  out  1  output byte strobe
ts_usb_almost_full  in  1  downstream cannot accept more (margin ≥2 bytes)
fifo_aclr  in  1  synchronous clear of alignment state
in_sync  out  1  alignment locked
drop_cnt  out  16  bytes dropped while unsynced (wraps)
sync_loss_cnt  out  16  synced->unsynced transitions (wraps)
buf_cnt  out  16  endpoint buffers consumed (wraps)
arm_timeout_cnt  out  8  ARM_WAIT timeouts (wraps)

Behaviour:
- Async reset (reset_n low): all outputs 0, state IDLE, pkt_pos 0, in_sync 0, internal len/addr 0.
- State machine:
  - IDLE: has_data && len!=0 -> latch len, addr=0, go READ. has_data && len==0 -> ARM.
  - READ: in each cycle with ts_usb_almost_full low, present addr and mark a read in flight (rd_v<=1 next cycle).
    - Not last byte: addr increments.
    - addr==len-1 issued -> DRAIN.
    - almost_full high: addr holds, no issue.
  - DRAIN: one cycle for last in-flight byte -> ARM.
  - ARM: ep2_usb_out_arm=1 for exactly one cycle, buf_cnt+1 -> ARM_WAIT.
  - ARM_WAIT: has_data low -> IDLE. Otherwise, after ARM_TIMEOUT cycles -> IDLE with arm_timeout_cnt+1.
- Data pipeline: byte read at issue cycle N arrives at N+1 and is registered to ts_usb_data/ts_usb_writereq at N+2. Latency addr->strobe = 2 cycles. At most 1 byte in flight, covered by the almost_full margin.
- Alignment, SYNC_CHECK=1, evaluated per arriving byte:
  - pkt_pos==0, byte==SYNC_BYTE: forward, pkt_pos=1, in_sync=1.
  - pkt_pos==0, byte!=SYNC_BYTE: not forwarded, drop_cnt+1. If in_sync was 1: sync_loss_cnt+1, in_sync=0.
  - pkt_pos!=0: forward. pkt_pos wraps PKT_LEN-1 -> 0.
  - Alignment state persists across buffers; a packet may span USB buffers.
- SYNC_CHECK=0: every byte is forwarded. in_sync stays 0. drop_cnt and sync_loss_cnt stay 0.
- fifo_aclr high: pkt_pos=0, in_sync=0. Counters are not cleared. Any in-flight byte is still evaluated, at pkt_pos 0.
- Counters wrap modulo width.
- Reset mid-READ: immediate IDLE, no arm pulse. The buffer is re-read in full once has_data is seen again.
- ts_usb_writereq is never asserted in a cycle not directly derived from a read issued while almost_full was low.

Test Plan:
1. Buffer len=376, two aligned packets (0x47 at bytes 0 and 188), almost_full=0 -> 376 strobes, first strobe 2 cycles after first addr, one arm pulse, buf_cnt=1, in_sync=1, drop_cnt=0.
2. Buffer len=200: 12 bytes 0x00, then 188-byte packet -> 12 drops (drop_cnt=12), 188 strobes, in_sync=1 after byte 12, sync_loss_cnt=0.
3. Aligned stream; almost_full held high for 20 cycles mid-buffer -> addr frozen, no strobes after the one in-flight byte, byte order intact, total strobes = len.
4. Packet split 100/88 across two buffers; second buffer's next packet has 0x55 in place of 0x47 -> first packet fully forwarded; on the 0x55, sync_loss_cnt=1, in_sync=0, drop_cnt increments.
5. len=0 buffer -> no strobes, one arm pulse. has_data kept high after arm -> IDLE after 15 cycles, arm_timeout_cnt=1.
6. reset_n low at byte 50 of 188 -> all outputs 0 within the same cycle. After release, re-read gives 188 strobes from addr 0, buf_cnt=1.
